huc6260_palette_ctrl: RTL and testbench

- CPU-side sequencer for the HuC6260 colour-table RAM (512 x 9-bit dual-port palette).
- Decodes the VCE register window: control, colour-table address (CTA), write data (CTW) and read data (CTR).
- Drives palette port A with CTA auto-increment and read prefetch. Port B stays owned by the video fetch path and is not touched here.
- Sits between the CPU bus decoder and the palette instance.

---
 rtl/huc6260_palette_ctrl_pkg.sv | 26 ++
 rtl/huc6260_palette_ctrl_cta_counter.sv | 33 +++
 rtl/huc6260_palette_ctrl.sv | 158 +++++++++++++++
 tb/tb_huc6260_palette_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/huc6260_palette_ctrl_pkg.sv
// Shared definitions for the HuC6260 VCE colour-table sequencer:
// register indices, sequencer states and palette depth.
package huc6260_pkg;

    localparam int PAL_ENTRIES = 512;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_RSVD   = 3'd1;
    localparam logic [2:0] REG_CTA_LO = 3'd2;
    localparam logic [2:0] REG_CTA_HI = 3'd3;
    localparam logic [2:0] REG_CTW_LO = 3'd4;
    localparam logic [2:0] REG_CTW_HI = 3'd5;
    localparam logic [2:0] REG_CTR_LO = 3'd6;
    localparam logic [2:0] REG_CTR_HI = 3'd7;

    // ST_STEP is the post-read cycle in which CTA advances before the prefetch
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_STEP     = 3'd2,
        ST_PREFETCH = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_CLEAR    = 3'd5
    } state_t;

endpackage

// File: rtl/huc6260_palette_ctrl_cta_counter.sv
// Colour-table address register: byte-wise loads from the CPU and a
// wrapping auto-increment used after CTW writes and CTR-high reads.
module huc6260_cta_counter
    import huc6260_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load_lo,
    input  logic                  i_load_hi,
    input  logic                  i_inc,
    input  logic [7:0]            i_din,
    output logic [ADDR_WIDTH-1:0] o_cta
);

    logic [ADDR_WIDTH-1:0] r_cta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cta <= '0;
        end else if (i_load_lo) begin
            r_cta[7:0] <= i_din;
        end else if (i_load_hi) begin
            r_cta[ADDR_WIDTH-1:8] <= i_din[ADDR_WIDTH-9:0];
        end else if (i_inc) begin
            r_cta <= r_cta + 1'b1;
        end
    end

    assign o_cta = r_cta;

endmodule

// File: rtl/huc6260_palette_ctrl.sv
// CPU-side sequencer for the HuC6260 colour-table RAM port A.
// Optional power-up palette clear: define HUC6260_PALETTE_CLEAR_EN.
module huc6260_palette_ctrl
    import huc6260_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_addr,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_ack,
    output logic [7:0]            ctrl_reg,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] pal_addr,
    output logic [DATA_WIDTH-1:0] pal_data,
    output logic                  pal_wren,
    input  logic [DATA_WIDTH-1:0] pal_q
);

`ifdef HUC6260_PALETTE_CLEAR_EN
    localparam state_t ST_RESET = ST_CLEAR;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_wr;
    logic                  w_rd;
    logic [ADDR_WIDTH-1:0] w_cta;
    logic [7:0]            r_wlo;
    logic [DATA_WIDTH-1:0] r_rbuf;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_dout;
    logic                  r_ack;
    logic [7:0]            r_ctrl;

    assign w_accept = (r_state == ST_IDLE) && cpu_req;
    assign w_wr     = w_accept && cpu_we;
    assign w_rd     = w_accept && !cpu_we;

    huc6260_cta_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_cta (
        .clock     (clock),
        .reset     (reset),
        .i_load_lo (w_wr && (cpu_addr == REG_CTA_LO)),
        .i_load_hi (w_wr && (cpu_addr == REG_CTA_HI)),
        .i_inc     ((r_state == ST_WRITE) || (r_state == ST_STEP)),
        .i_din     (cpu_din),
        .o_cta     (w_cta)
    );

`ifdef HUC6260_PALETTE_CLEAR_EN
    logic [ADDR_WIDTH-1:0] r_clr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr <= r_clr + 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr && ((cpu_addr == REG_CTA_LO) || (cpu_addr == REG_CTA_HI))) begin
                    w_next = ST_PREFETCH;
                end else if (w_wr && (cpu_addr == REG_CTW_HI)) begin
                    w_next = ST_WRITE;
                end else if (w_rd && (cpu_addr == REG_CTR_HI)) begin
                    w_next = ST_STEP;
                end
            end
            ST_WRITE:    w_next = ST_IDLE;
            ST_STEP:     w_next = ST_PREFETCH;
            ST_PREFETCH: w_next = ST_CAPTURE;
            ST_CAPTURE:  w_next = ST_IDLE;
            ST_CLEAR: begin
`ifdef HUC6260_PALETTE_CLEAR_EN
                if (r_clr == ADDR_WIDTH'(PAL_ENTRIES - 1)) begin
                    w_next = ST_IDLE;
                end
`else
                w_next = ST_IDLE;
`endif
            end
            default:     w_next = ST_IDLE;
        endcase
    end

    // Write enable is decoded from state so an async reset kills it at once
    always_comb begin
        busy     = (r_state != ST_IDLE);
        pal_wren = (r_state == ST_WRITE);
        pal_addr = w_cta;
        pal_data = r_wdata;
`ifdef HUC6260_PALETTE_CLEAR_EN
        if (r_state == ST_CLEAR) begin
            pal_wren = 1'b1;
            pal_addr = r_clr;
            pal_data = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wlo   <= '0;
            r_rbuf  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_ack   <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_ack <= w_accept;
            if (w_wr) begin
                case (cpu_addr)
                    REG_CTRL:   r_ctrl  <= cpu_din;
                    REG_CTW_LO: r_wlo   <= cpu_din;
                    REG_CTW_HI: r_wdata <= DATA_WIDTH'({cpu_din[0], r_wlo});
                    default:    ;
                endcase
            end
            if (w_rd) begin
                case (cpu_addr)
                    REG_CTRL:   r_dout <= r_ctrl;
                    REG_CTR_LO: r_dout <= r_rbuf[7:0];
                    REG_CTR_HI: r_dout <= {7'h7F, r_rbuf[8]};
                    default:    r_dout <= 8'hFF;
                endcase
            end
            if (r_state == ST_CAPTURE) begin
                r_rbuf <= pal_q;
            end
        end
    end

    assign cpu_dout = r_dout;
    assign cpu_ack  = r_ack;
    assign ctrl_reg = r_ctrl;

endmodule

// File: tb/tb_huc6260_palette_ctrl.sv
// Randomised bench for huc6260_palette_ctrl against a transaction-level
// model of the VCE colour-table registers and palette contents.
module tb_huc6260_palette_ctrl;

`ifdef HUC6260_PALETTE_CLEAR_EN
    localparam logic CLR = 1'b1;
`else
    localparam logic CLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req;
    logic       cpu_we;
    logic [2:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_ack;
    logic [7:0] ctrl_reg;
    logic       busy;
    logic [8:0] pal_addr;
    logic [8:0] pal_data;
    logic       pal_wren;
    logic [8:0] pal_q;

    huc6260_palette_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(9)) dut (
        .clock    (clk),
        .reset    (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_ack  (cpu_ack),
        .ctrl_reg (ctrl_reg),
        .busy     (busy),
        .pal_addr (pal_addr),
        .pal_data (pal_data),
        .pal_wren (pal_wren),
        .pal_q    (pal_q)
    );

    always #5 clk = ~clk;

    logic [8:0] ram [512];
    logic [8:0] mram[512];
    logic [8:0] m_cta, m_rbuf;
    logic [7:0] m_wlo, m_ctrl;
    int         pend;
    logic [17:0] exp_wq[$];
    int         n_checks = 0, n_fail = 0;
    int         n_wren = 0, n_pushed = 0;
    int         cyc = 0;
    int         last_ack_cyc;
    bit         clearing = CLR;

    always @(posedge clk) begin
        if (pal_wren) ram[pal_addr] <= pal_data;
        pal_q <= ram[pal_addr];
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pal_wren && !clearing && !rst) begin
            n_wren++;
            if (exp_wq.size() == 0) begin
                check("wren_spurious", 32'(exp_wq.size()), 32'(1));
            end else begin
                logic [17:0] e;
                e = exp_wq.pop_front();
                check("wren_addr", 32'(pal_addr), 32'(e[17:9]));
                check("wren_data", 32'(pal_data), 32'(e[8:0]));
            end
        end
    end

    task automatic model_reset();
        m_cta  = '0;
        m_rbuf = '0;
        m_wlo  = '0;
        m_ctrl = '0;
        pend   = 0;
    endtask

    task automatic model(input logic we, input logic [2:0] a, input logic [7:0] d,
                         output logic [7:0] e_dout, output logic [8:0] e_addr);
        e_dout = 8'hFF;
        e_addr = m_cta;
        pend   = 0;
        if (we) begin
            case (a)
                3'd0: m_ctrl = d;
                3'd2: begin m_cta = {m_cta[8], d}; m_rbuf = mram[m_cta]; pend = 2; e_addr = m_cta; end
                3'd3: begin m_cta = {d[0], m_cta[7:0]}; m_rbuf = mram[m_cta]; pend = 2; e_addr = m_cta; end
                3'd4: m_wlo = d;
                3'd5: begin
                    exp_wq.push_back({m_cta, d[0], m_wlo});
                    n_pushed++;
                    mram[m_cta] = {d[0], m_wlo};
                    m_cta = m_cta + 9'd1;
                    pend = 1;
                end
                default: ;
            endcase
        end else begin
            case (a)
                3'd0: e_dout = m_ctrl;
                3'd6: e_dout = m_rbuf[7:0];
                3'd7: begin
                    e_dout = {7'h7F, m_rbuf[8]};
                    m_cta  = m_cta + 9'd1;
                    m_rbuf = mram[m_cta];
                    pend   = 3;
                end
                default: e_dout = 8'hFF;
            endcase
        end
    endtask

    task automatic access(input logic we, input logic [2:0] a, input logic [7:0] d,
                          input int gap, output logic [7:0] rd);
        int k, exp_k;
        logic [7:0] e_dout;
        logic [8:0] e_addr;
        @(posedge clk); #1;
        check("ack_single", 32'(cpu_ack), 32'(0));
        @(negedge clk);
        for (int i = 0; i < gap; i++) @(negedge clk);
        exp_k = (pend - gap > 1) ? pend - gap : 1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!cpu_ack && k < 2000);
        cpu_req = 1'b0;
        last_ack_cyc = cyc;
        rd = cpu_dout;
        model(we, a, d, e_dout, e_addr);
        check($sformatf("ack_latency_%s%0d", we ? "w" : "r", a), 32'(k), 32'(exp_k));
        if (!we) check($sformatf("rd_reg%0d", a), 32'(cpu_dout), 32'(e_dout));
        check("pal_addr", 32'(pal_addr), 32'(e_addr));
        check("ctrl_reg", 32'(ctrl_reg), 32'(m_ctrl));
        if (we && a == 3'd5) begin
            check("wren_in_ack", 32'(pal_wren), 32'(1));
            check("wr_data", 32'(pal_data), 32'(mram[e_addr]));
        end
    endtask

    task automatic post_reset();
`ifdef HUC6260_PALETTE_CLEAR_EN
        int cnt, early;
        cnt = 0; early = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd0; cpu_din = 8'h00;
        while (busy && cnt < 1000) begin
            if (cpu_ack) early++;
            cnt++;
            @(negedge clk);
        end
        check("clear_busy_cycles", 32'(cnt), 32'(512));
        check("clear_early_ack", 32'(early), 32'(0));
        @(posedge clk); #1;
        check("clear_req_ack", 32'(cpu_ack), 32'(1));
        check("clear_rd_ctrl", 32'(cpu_dout), 32'(0));
        cpu_req = 1'b0;
        for (int i = 0; i < 512; i++) mram[i] = '0;
        clearing = 1'b0;
`endif
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},  32'(cpu_dout), 32'(0));
        check({tag, "_ack"},   32'(cpu_ack),  32'(0));
        check({tag, "_busy"},  32'(busy),     32'(CLR));
        check({tag, "_wren"},  32'(pal_wren), 32'(CLR));
        check({tag, "_addr"},  32'(pal_addr), 32'(0));
        check({tag, "_data"},  32'(pal_data), 32'(0));
        check({tag, "_ctrl"},  32'(ctrl_reg), 32'(0));
    endtask

    initial begin
        logic [7:0] rd;
        logic [8:0] saved;
        int         prev;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        for (int i = 0; i < 512; i++) begin
            ram[i]  = 9'($urandom);
            mram[i] = ram[i];
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        post_reset();

        // control register and reserved slot
        access(1'b1, 3'd0, 8'h87, 0, rd);
        check("ctrl_87", 32'(ctrl_reg), 32'h87);
        access(1'b1, 3'd1, 8'h55, 0, rd);
        check("ctrl_kept", 32'(ctrl_reg), 32'h87);
        access(1'b0, 3'd1, 8'h00, 0, rd);
        check("rd_reg1_ff", 32'(rd), 32'hFF);

        // CTW writes across the top of the table
        access(1'b1, 3'd2, 8'hFE, 0, rd);
        access(1'b1, 3'd3, 8'h01, 1, rd);
        access(1'b1, 3'd4, 8'h34, 0, rd);
        access(1'b1, 3'd5, 8'h01, 0, rd);
        check("ctw_addr_1fe", 32'(pal_addr), 32'h1FE);
        check("ctw_data_134", 32'(pal_data), 32'h134);
        access(1'b1, 3'd4, 8'h9C, 0, rd);
        access(1'b1, 3'd5, 8'h00, 0, rd);
        check("ctw_addr_1ff", 32'(pal_addr), 32'h1FF);
        access(1'b1, 3'd4, 8'h11, 2, rd);
        access(1'b1, 3'd5, 8'h01, 0, rd);
        check("ctw_addr_wrap", 32'(pal_addr), 32'h000);

        // read path with prefetch
        access(1'b1, 3'd2, 8'h10, 0, rd);
        access(1'b1, 3'd3, 8'h00, 0, rd);
        access(1'b1, 3'd4, 8'hA5, 0, rd);
        access(1'b1, 3'd5, 8'h01, 0, rd);
        access(1'b1, 3'd2, 8'h10, 0, rd);
        access(1'b0, 3'd6, 8'h00, 0, rd);
        check("ctr_lo_a5", 32'(rd), 32'hA5);
        access(1'b0, 3'd7, 8'h00, 0, rd);
        check("ctr_hi_ff", 32'(rd), 32'hFF);
        prev = last_ack_cyc;
        access(1'b0, 3'd7, 8'h00, 0, rd);
        check("ack_spacing_ctr_hi", 32'(last_ack_cyc - prev), 32'(4));
        access(1'b0, 3'd6, 8'h00, 0, rd);

        for (int n = 0; n < 300; n++) begin
            access(1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(0, 3)), rd);
        end

        // reset landing in the WRITE cycle
        access(1'b1, 3'd2, 8'h20, 0, rd);
        access(1'b1, 3'd3, 8'h00, 0, rd);
        saved = mram[9'h020];
        access(1'b1, 3'd4, ~saved[7:0], 0, rd);
        access(1'b1, 3'd5, {7'h00, ~saved[8]}, 0, rd);
        clearing = CLR;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_wq.delete();
        n_pushed--;
        mram[9'h020] = saved;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("release");
        post_reset();
        access(1'b1, 3'd2, 8'h20, 0, rd);
        access(1'b1, 3'd3, 8'h00, 0, rd);
        access(1'b0, 3'd6, 8'h00, 0, rd);
        access(1'b0, 3'd7, 8'h00, 0, rd);

        repeat (6) @(negedge clk);
        check("wq_drained", 32'(exp_wq.size()), 32'(0));
        check("wren_count", 32'(n_wren), 32'(n_pushed));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
